// File: rtl/test_sequencer.sv
// Campaign controller: runs up to NUM_PHASES clear/run/drain/capture phases of the
// arithmetic testbench, each with its own fault-injection configuration.
module test_sequencer #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned NUM_PHASES   = 4,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned DRAIN_MARGIN = 4,
  localparam int unsigned PW = $clog2(NUM_PHASES),
  localparam int unsigned CW = 4 * WIDTH + 1
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_run_len,
  input  logic             i_cfg_we,
  input  logic [PW-1:0]    i_cfg_addr,
  input  logic [CW-1:0]    i_cfg_wdata,
  input  logic [31:0]      i_data_ctr,
  input  logic [31:0]      i_error_ctr,
  input  logic [31:0]      i_dut_delay,
  output logic             o_tb_reset,
  output logic             o_enable,
  output logic             o_freeze,
  output logic             o_fselect,
  output logic [WIDTH-1:0] o_fbitset_a,
  output logic [WIDTH-1:0] o_fbitset_b,
  output logic [WIDTH-1:0] o_fbitclr_a,
  output logic [WIDTH-1:0] o_fbitclr_b,
  output logic [PW-1:0]    o_phase,
  output logic             o_busy,
  output logic             o_phase_valid,
  output logic [31:0]      o_phase_errors,
  output logic [31:0]      o_total_errors,
  output logic             o_done,
  output logic             o_aborted
);

  typedef struct packed {
    logic             fselect;
    logic [WIDTH-1:0] bitset_a;
    logic [WIDTH-1:0] bitset_b;
    logic [WIDTH-1:0] bitclr_a;
    logic [WIDTH-1:0] bitclr_b;
  } fault_cfg_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  localparam logic [31:0]   CLEAR_LOAD = 32'(CLEAR_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [31:0]     run_len_q, run_len_d;
  fault_cfg_t      cfg_q [NUM_PHASES];
  fault_cfg_t      fault_q, fault_d;
  fault_cfg_t      cfg_rd;

  logic            tb_reset_q, tb_reset_d;
  logic            enable_q, enable_d;
  logic            freeze_q, freeze_d;
  logic            busy_q, busy_d;
  logic            phase_valid_q, phase_valid_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic [31:0]     phase_err_q, phase_err_d;
  logic [31:0]     total_err_q, total_err_d;

  logic            start_take;
  logic            abort_take;
  logic            cfg_wr;
  logic [32:0]     drain_sum;
  logic [31:0]     drain_load;
  logic [32:0]     total_sum;
  logic [31:0]     total_sat;

  assign start_take = (state_q == IDLE) && i_start;
  assign abort_take = (state_q != IDLE) && i_abort;
  assign cfg_wr     = (state_q == IDLE) && i_cfg_we && (32'(i_cfg_addr) < NUM_PHASES);

  // Saturating drain length and error accumulation
  assign drain_sum  = {1'b0, i_dut_delay} + 33'(DRAIN_MARGIN);
  assign drain_load = drain_sum[32] ? 32'hFFFF_FFFF : drain_sum[31:0];
  assign total_sum  = {1'b0, total_err_q} + {1'b0, i_error_ctr};
  assign total_sat  = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];

  // A write in the same cycle as start lands before the table is read
  always_comb begin
    cfg_rd = cfg_q[phase_d];
    if (cfg_wr && (i_cfg_addr == phase_d)) begin
      cfg_rd = fault_cfg_t'(i_cfg_wdata);
    end
  end

  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    run_len_d = run_len_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = CLEAR;
          run_len_d = i_run_len;
          phase_d   = '0;
          cnt_d     = CLEAR_LOAD;
        end
      end
      CLEAR: begin
        if (cnt_q == 32'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      RUN: begin
        if (i_data_ctr >= run_len_q) begin
          state_d = DRAIN;
          cnt_d   = drain_load;
        end
      end
      DRAIN: begin
        if (cnt_q == 32'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      CAPTURE: begin
        if (phase_q == LAST_PHASE) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          state_d = CLEAR;
          phase_d = phase_q + PW'(1);
          cnt_d   = CLEAR_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    if (abort_take) begin
      state_d = IDLE;
      phase_d = '0;
    end
  end

  // Registered outputs follow the state being entered
  always_comb begin
    tb_reset_d    = (state_d == CLEAR);
    enable_d      = (state_d == RUN);
    freeze_d      = (state_d == IDLE) || (state_d == CAPTURE);
    busy_d        = (state_d != IDLE);
    phase_valid_d = (state_d == CAPTURE);
    done_d        = (state_q == CAPTURE) && (state_d == IDLE) && !abort_take;
    aborted_d     = abort_take;
    phase_err_d   = phase_err_q;
    total_err_d   = total_err_q;
    fault_d       = fault_q;
    if (state_d == IDLE) begin
      fault_d = '0;
    end else if ((state_d == CLEAR) && (state_q != CLEAR)) begin
      fault_d = cfg_rd;
    end
    if (start_take) begin
      total_err_d = 32'd0;
    end
    if (state_d == CAPTURE) begin
      phase_err_d = i_error_ctr;
      total_err_d = total_sat;
    end
  end

  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      cnt_q         <= 32'd0;
      phase_q       <= '0;
      run_len_q     <= 32'd0;
      fault_q       <= '0;
      tb_reset_q    <= 1'b0;
      enable_q      <= 1'b0;
      freeze_q      <= 1'b1;
      busy_q        <= 1'b0;
      phase_valid_q <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      phase_err_q   <= 32'd0;
      total_err_q   <= 32'd0;
      for (int i = 0; i < int'(NUM_PHASES); i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      run_len_q     <= run_len_d;
      fault_q       <= fault_d;
      tb_reset_q    <= tb_reset_d;
      enable_q      <= enable_d;
      freeze_q      <= freeze_d;
      busy_q        <= busy_d;
      phase_valid_q <= phase_valid_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      phase_err_q   <= phase_err_d;
      total_err_q   <= total_err_d;
      if (cfg_wr) begin
        cfg_q[i_cfg_addr] <= fault_cfg_t'(i_cfg_wdata);
      end
    end
  end

  assign o_tb_reset     = tb_reset_q;
  assign o_enable       = enable_q;
  assign o_freeze       = freeze_q;
  assign o_fselect      = fault_q.fselect;
  assign o_fbitset_a    = fault_q.bitset_a;
  assign o_fbitset_b    = fault_q.bitset_b;
  assign o_fbitclr_a    = fault_q.bitclr_a;
  assign o_fbitclr_b    = fault_q.bitclr_b;
  assign o_phase        = phase_q;
  assign o_busy         = busy_q;
  assign o_phase_valid  = phase_valid_q;
  assign o_phase_errors = phase_err_q;
  assign o_total_errors = total_err_q;
  assign o_done         = done_q;
  assign o_aborted      = aborted_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: a stub arithmetic testbench plus a scoreboard
// of expected per-phase error captures and campaign totals.
module tb_test_sequencer;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NP    = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 4 * WIDTH + 1;
  localparam int unsigned CLR   = 2;

  logic             clk_dut = 1'b0;
  logic             reset;
  logic             i_start, i_abort, i_cfg_we;
  logic [31:0]      i_run_len;
  logic [PW-1:0]    i_cfg_addr;
  logic [CW-1:0]    i_cfg_wdata;
  logic [31:0]      i_data_ctr, i_error_ctr, i_dut_delay;
  logic             o_tb_reset, o_enable, o_freeze, o_fselect, o_busy;
  logic [WIDTH-1:0] o_fbitset_a, o_fbitset_b, o_fbitclr_a, o_fbitclr_b;
  logic [PW-1:0]    o_phase;
  logic             o_phase_valid, o_done, o_aborted;
  logic [31:0]      o_phase_errors, o_total_errors;

  test_sequencer dut (
    .clk_dut(clk_dut), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_run_len(i_run_len), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
    .i_cfg_wdata(i_cfg_wdata), .i_data_ctr(i_data_ctr), .i_error_ctr(i_error_ctr),
    .i_dut_delay(i_dut_delay), .o_tb_reset(o_tb_reset), .o_enable(o_enable),
    .o_freeze(o_freeze), .o_fselect(o_fselect), .o_fbitset_a(o_fbitset_a),
    .o_fbitset_b(o_fbitset_b), .o_fbitclr_a(o_fbitclr_a), .o_fbitclr_b(o_fbitclr_b),
    .o_phase(o_phase), .o_busy(o_busy), .o_phase_valid(o_phase_valid),
    .o_phase_errors(o_phase_errors), .o_total_errors(o_total_errors),
    .o_done(o_done), .o_aborted(o_aborted)
  );

  always #5 clk_dut = ~clk_dut;

  // Stub testbench: counts samples while enabled, one error per sample when any fault is set
  logic [31:0] data_ctr = 32'd0;
  logic [31:0] err_ctr  = 32'd0;
  logic        err_ovr_en = 1'b0;
  logic [31:0] dly = 32'd3;
  logic        fault_on;
  assign fault_on    = o_fselect | (|o_fbitset_a) | (|o_fbitset_b) | (|o_fbitclr_a) | (|o_fbitclr_b);
  assign i_data_ctr  = data_ctr;
  assign i_error_ctr = err_ovr_en ? 32'hFFFF_FFFF : err_ctr;
  assign i_dut_delay = dly;

  always @(posedge clk_dut) begin
    if (o_tb_reset) begin
      data_ctr <= 32'd0;
      err_ctr  <= 32'd0;
    end else if (o_enable) begin
      data_ctr <= data_ctr + 32'd1;
      if (fault_on) err_ctr <= err_ctr + 32'd1;
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          cyc_num = 0;
  int          en_cnt = 0;
  int          run_len_cur = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;
  int          last_valid_cyc = -10;
  int          start_pres = 0;
  bit          lat_pending = 1'b0;
  logic        prev_tbr = 1'b0;
  logic        prev_busy = 1'b0;
  logic [31:0] expq[$];
  logic [31:0] exp_total;
  logic [31:0] exp_part;
  logic [CW-1:0] tb_cfg [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [31:0] exp_err(input int p, input int rl, input bit ovr);
    if (ovr) return 32'hFFFF_FFFF;
    return (tb_cfg[p] != '0) ? 32'(rl + 1) : 32'd0;
  endfunction

  // One clock plus the per-cycle monitor, sampled 1 ns after the edge
  task automatic cyc();
    logic [CW-1:0] fo;
    @(posedge clk_dut);
    #1;
    cyc_num++;
    fo = {o_fselect, o_fbitset_a, o_fbitset_b, o_fbitclr_a, o_fbitclr_b};
    if (lat_pending && o_enable) begin
      chk("start_latency", 32'(cyc_num - start_pres), 32'(CLR + 1));
      lat_pending = 1'b0;
    end
    if (o_enable) en_cnt++;
    if (o_tb_reset && !prev_tbr) chk_cfg("fault_cfg", fo, tb_cfg[o_phase]);
    if (!o_busy && prev_busy) chk_cfg("fault_idle", fo, '0);
    if (o_phase_valid) begin
      if (run_len_cur == 0) chk("run_len0_enable", 32'(en_cnt), 32'd1);
      else chk("enable_cycles", 32'(en_cnt >= run_len_cur), 32'd1);
      en_cnt = 0;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=%h expected=none", o_phase_errors);
      end else begin
        chk("phase_errors", o_phase_errors, expq.pop_front());
      end
      last_valid_cyc = cyc_num;
    end
    if (o_done) begin
      done_cnt++;
      chk("done_after_capture", 32'(cyc_num), 32'(last_valid_cyc + 1));
      chk("total_at_done", o_total_errors, exp_total);
    end
    if (o_aborted) abort_cnt++;
    prev_tbr  = o_tb_reset;
    prev_busy = o_busy;
  endtask

  task automatic cfg_write(input int addr, input logic [CW-1:0] data);
    i_cfg_we    = 1'b1;
    i_cfg_addr  = PW'(addr);
    i_cfg_wdata = data;
    if (!o_busy) tb_cfg[addr] = data;
    cyc();
    i_cfg_we = 1'b0;
  endtask

  task automatic start_campaign(input int rl, input bit ovr, input bit ab,
                                input bit we, input int waddr, input logic [CW-1:0] wdata);
    if (we) begin
      tb_cfg[waddr] = wdata;
      i_cfg_we      = 1'b1;
      i_cfg_addr    = PW'(waddr);
      i_cfg_wdata   = wdata;
    end
    exp_total = 32'd0;
    exp_part  = 32'd0;
    for (int p = 0; p < int'(NP); p++) begin
      expq.push_back(exp_err(p, rl, ovr));
      exp_total = sat_add(exp_total, exp_err(p, rl, ovr));
      if (p < 2) exp_part = sat_add(exp_part, exp_err(p, rl, ovr));
    end
    i_run_len   = 32'(rl);
    i_start     = 1'b1;
    i_abort     = ab;
    run_len_cur = rl;
    en_cnt      = 0;
    start_pres  = cyc_num;
    lat_pending = 1'b1;
    cyc();
    i_start  = 1'b0;
    i_abort  = 1'b0;
    i_cfg_we = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < 3000 && done_cnt == d0; n++) cyc();
    for (int n = 0; n < 5; n++) cyc();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("queue_drained", 32'(expq.size()), 32'd0);
  endtask

  // drain=1 waits for DRAIN of phase ph, drain=0 for RUN of phase ph
  task automatic wait_state(input int ph, input bit drain);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      cyc();
      if (o_phase == PW'(ph) && o_busy &&
          (drain ? (!o_enable && !o_tb_reset && !o_freeze) : o_enable)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL wait_state phase=%0d drain=%0b observed=timeout expected=reached", ph, drain);
    end
  endtask

  task automatic do_abort();
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    chk("aborted_pulse", 32'(o_aborted), 32'd1);
    chk("idle_after_abort", 32'(o_busy), 32'd0);
    chk("no_phase_valid_on_abort", 32'(o_phase_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tb_reset", 32'(o_tb_reset), 32'd0);
    chk("rst_enable", 32'(o_enable), 32'd0);
    chk("rst_freeze", 32'(o_freeze), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_phase", 32'(o_phase), 32'd0);
    chk("rst_pulses", 32'({o_phase_valid, o_done, o_aborted}), 32'd0);
    chk("rst_phase_errors", o_phase_errors, 32'd0);
    chk("rst_total_errors", o_total_errors, 32'd0);
    chk_cfg("rst_fault", {o_fselect, o_fbitset_a, o_fbitset_b, o_fbitclr_a, o_fbitclr_b}, '0);
  endtask

  initial begin
    int d0;
    logic [CW-1:0] fault1;
    logic [CW-1:0] fault0;
    fault1 = {1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    fault0 = {1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
    for (int p = 0; p < int'(NP); p++) tb_cfg[p] = '0;
    reset = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_cfg_we = 1'b0;
    i_run_len = 32'd0; i_cfg_addr = '0; i_cfg_wdata = '0;
    #23;
    chk_reset_outputs();
    reset = 1'b1;
    cyc();
    cyc();
    chk_reset_outputs();

    // Abort in IDLE is ignored; start+abort in IDLE takes the start
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    chk("idle_abort_ignored", 32'({o_aborted, o_busy}), 32'd0);

    // Basic all-zero campaign
    start_campaign(100, 1'b0, 1'b1, 1'b0, 0, '0);
    chk("busy_after_start", 32'(o_busy), 32'd1);
    wait_done();
    chk("idle_after_done", 32'(o_busy), 32'd0);

    // Fault on phase 1 only
    cfg_write(1, fault1);
    start_campaign(64, 1'b0, 1'b0, 1'b0, 0, '0);
    wait_done();

    // Abort during DRAIN of phase 2
    start_campaign(64, 1'b0, 1'b0, 1'b0, 0, '0);
    d0 = done_cnt;
    wait_state(2, 1'b1);
    do_abort();
    chk("abort_total_hold", o_total_errors, exp_part);
    chk("abort_pending_caps", 32'(expq.size()), 32'd2);
    expq.delete();
    for (int n = 0; n < 4; n++) cyc();
    chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);

    // run_len = 0: RUN lasts one cycle per phase
    start_campaign(0, 1'b0, 1'b0, 1'b0, 0, '0);
    wait_done();

    // Saturated drain load, then abort out of the huge drain
    dly = 32'hFFFF_FFFE;
    start_campaign(0, 1'b0, 1'b0, 1'b0, 0, '0);
    wait_state(0, 1'b1);
    chk("drain_load_saturated", dut.cnt_q, 32'hFFFF_FFFF);
    do_abort();
    expq.delete();
    dly = 32'd3;

    // Saturating total with maximal error counts
    err_ovr_en = 1'b1;
    start_campaign(4, 1'b1, 1'b0, 1'b0, 0, '0);
    wait_done();
    err_ovr_en = 1'b0;

    // Config write while busy is dropped
    start_campaign(8, 1'b0, 1'b0, 1'b0, 0, '0);
    cyc();
    cfg_write(1, '0);
    wait_done();
    start_campaign(8, 1'b0, 1'b0, 1'b0, 0, '0);
    wait_done();

    // Start together with a write to entry 0
    start_campaign(8, 1'b0, 1'b0, 1'b1, 0, fault0);
    wait_done();

    // Reset during RUN of phase 2 clears everything including the table
    start_campaign(100, 1'b0, 1'b0, 1'b0, 0, '0);
    wait_state(2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    chk("rst_state_idle", 32'(dut.state_q), 32'd0);
    expq.delete();
    for (int p = 0; p < int'(NP); p++) tb_cfg[p] = '0;
    @(negedge clk_dut);
    reset = 1'b1;
    cyc();
    start_campaign(16, 1'b0, 1'b0, 1'b0, 0, '0);
    wait_done();
    chk("aborts_seen", 32'(abort_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
Campaign controller for the arithmetic testbench. It steps through up to NUM_PHASES test phases. Each phase has its own fault-injection configuration, taken from a small config table. For every phase the block clears the testbench, runs it for a programmed number of scored samples, drains the DUT pipeline, freezes the counters and captures that phase's error count. It drives the testbench's reset, enable, freeze and fault-injection inputs, and reads back the data, error and DUT-delay counters.

Parameters:
WIDTH, 16, operand width; must match the testbench.
NUM_PHASES, 4, number of config-table entries (must be ≥2). PW = $clog2(NUM_PHASES).
CLEAR_CYCLES, 2, cycles o_tb_reset is held high per phase (≥1).
DRAIN_MARGIN, 4, extra drain cycles added to i_dut_delay.

Ports:
clk_dut  in  1  single clock
reset  in  1  asynchronous, active-low
i_start  in  1  single-cycle start pulse
i_abort  in  1  abort request
i_run_len  in  32  scored samples per phase; sampled at start
i_cfg_we  in  1  config-table write strobe
i_cfg_addr  in  PW  config-table entry
i_cfg_wdata  in  4*WIDTH+1  {fselect, bitset_a, bitset_b, bitclr_a, bitclr_b}, with fselect as the MSB
i_data_ctr  in  32  testbench data counter
i_error_ctr  in  32  testbench error counter
i_dut_delay  in  32  testbench measured DUT delay
o_tb_reset  out  1  active-high reset to the testbench
o_enable  out  1  testbench enable
o_freeze  out  1  testbench scoreboard freeze
o_fselect  out  1  fault-select field of the current phase
o_fbitset_a, o_fbitset_b, o_fbitclr_a, o_fbitclr_b  out  WIDTH each  fault masks of the current phase
o_phase  out  PW  current phase index
o_busy  out  1  high in every state except IDLE
o_phase_valid  out  1  1-cycle pulse; o_phase_errors is valid
o_phase_errors  out  32  errors captured in the last completed phase
o_total_errors  out  32  saturating sum of captured errors for this campaign
o_done  out  1  1-cycle pulse when the campaign completes
o_aborted  out  1  1-cycle pulse when an abort is taken

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; the config table and all counters clear to 0.
  - Outputs: o_tb_reset=0, o_enable=0, o_freeze=1, fault outputs 0, o_phase=0, o_busy=0, all pulses 0, o_phase_errors=0, o_total_errors=0.
- States: IDLE, CLEAR, RUN, DRAIN, CAPTURE. All outputs are registered.
- IDLE:
  - o_enable=0, o_freeze=1.
  - i_start=1 does the following: latches i_run_len, sets phase=0, clears o_total_errors, then enters CLEAR.
  - Config writes are accepted only in IDLE. A write while busy is dropped.
- CLEAR:
  - o_tb_reset=1, o_enable=0, o_freeze=0 for CLEAR_CYCLES cycles, then RUN.
  - Fault outputs load from table[phase] on CLEAR entry. They stay stable until the next CLEAR entry or IDLE.
- RUN:
  - o_enable=1, o_freeze=0.
  - When i_data_ctr ≥ run_len (unsigned), go to DRAIN on the next cycle.
  - run_len=0: leave RUN after exactly one cycle.
- DRAIN:
  - o_enable=0, o_freeze=0.
  - On entry, load the down-counter with i_dut_delay+DRAIN_MARGIN, saturating at 2^32-1.
  - Go to CAPTURE when the counter reaches 0.
- CAPTURE: one cycle.
  - o_freeze=1, o_phase_errors ← i_error_ctr, o_phase_valid=1.
  - o_total_errors ← saturating sum of o_total_errors and i_error_ctr (holds at 2^32-1 on overflow).
  - If phase=NUM_PHASES-1: o_done=1, go to IDLE.
  - Otherwise: phase+1, go to CLEAR.
- Abort:
  - i_abort=1 in any busy state means the next state is IDLE with o_aborted=1.
  - o_done and o_phase_valid are not pulsed on that cycle.
  - o_phase_errors and o_total_errors hold their values.
  - Abort takes priority over every other transition, including one from CAPTURE.
  - In IDLE, i_abort is ignored.
- Simultaneous events:
  - i_start while busy is ignored.
  - i_start together with i_abort in IDLE: the start is taken.
  - i_cfg_we together with i_start in IDLE: the write lands first, so phase 0 uses the new data when addr=0.
- Fault outputs return to 0 in IDLE, after done or abort.
- Latency: start→first o_enable = CLEAR_CYCLES+1 cycles.

Test Plan:
- Reset mid-RUN (phase 2): deassert → IDLE, all outputs at reset values, config table reads 0 on the next campaign.
- Basic campaign, NUM_PHASES=4, run_len=100, all-zero config, internal adder as DUT:
  - 4 o_phase_valid pulses, each with o_phase_errors=0.
  - o_done exactly once, 1 cycle after the 4th capture.
  - o_enable high ≥100 cycles per phase.
- Fault phase: table[1] = {fselect=0, bitset_a=16'h0001, others 0}, run_len=64:
  - Phase 1 o_phase_errors > 0; phases 0, 2 and 3 report 0.
  - o_total_errors equals phase 1's count.
  - o_fbitset_a=16'h0001 only while o_phase=1.
- Abort during DRAIN of phase 2:
  - o_aborted pulse; IDLE next cycle; no o_done.
  - o_total_errors equals the sum of phases 0 and 1.
- Boundaries:
  - run_len=0 gives RUN lasting 1 cycle.
  - i_dut_delay=32'hFFFF_FFFE forces a saturated drain load; checked via a force/peek of the counter.
  - i_error_ctr=32'hFFFF_FFFF in two phases gives o_total_errors=32'hFFFF_FFFF.
- Write/start collisions:
  - A cfg write while busy is ignored: the next campaign sees the old value.
  - Start plus a write to addr 0 in the same IDLE cycle: phase 0 drives the new masks.
